// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared FSM encoding and sizing helper for the serial adder
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fa_bit.sv
// rtl/fa_bit.sv - combinational 1-bit full adder cell
module fa_bit (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder/subtractor around one full-adder cell
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_full;

    fa_bit u_fa (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_co)
    );

    // Working result: new sum bit enters at the MSB; after the last bit it is the full word.
    assign res_full = {fa_s, res_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    // Subtract is A + ~B + ~Cin: invert B here and fold the borrow into the carry.
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    carry_d = Cin ^ Sub;
                    cnt_d   = '0;
                    res_d   = '0;
                    cmsb_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                res_d   = res_full[WIDTH-1:1];
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_MSB_IN) begin
                    cmsb_d = fa_co;
                end
                if (cnt_q == CNT_LAST) begin
                    s_d     = res_full;
                    cout_d  = fa_co;
                    ovf_d   = cmsb_q ^ fa_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Busy = (state_q != ST_IDLE);
    assign Done = (state_q == ST_DONE);
    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule
